mdu_seq: RTL

Multi-cycle multiply/divide sequencer for the multicycle MIPS core. It executes MULT, MULTU, DIV and DIVU on rs/rt operands and owns the HI/LO architectural registers. It also accepts MTHI/MTLO writes. The main control FSM issues a start pulse and stalls in a wait state until done, then reads hi/lo for MFHI/MFLO write-back through the WriteData mux.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multi-cycle multiply/divide sequencer.
package mdu_pkg;

  localparam int unsigned MDU_W = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_t;

  function automatic logic is_signed(input mdu_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Magnitude of a two's-complement value when sgn is set, else the raw value.
  function automatic logic [MDU_W-1:0] abs_val(input logic [MDU_W-1:0] v, input logic sgn);
    return (sgn && v[MDU_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Magnitudes are iterated one bit per cycle; signs are applied in a single FIX cycle.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_W
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  mdu_state_t         state, state_nx;
  logic               busy_nx, done_nx, div_zero_nx;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opd;
  logic               sign_q, sign_r, div_op;

  mdu_op_t          op_e;
  logic             op_sgn, op_is_div, rt_zero, accept, last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;

  assign op_e      = mdu_op_t'(op);
  assign op_sgn    = is_signed(op_e);
  assign op_is_div = op_e[1];
  assign rt_zero   = (rt_val == '0);
  assign accept    = (state == ST_IDLE) && start;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign a_mag     = WIDTH'(abs_val(MDU_W'(rs_val), op_sgn));
  assign b_mag     = WIDTH'(abs_val(MDU_W'(rt_val), op_sgn));

  // Shift-add: upper half accumulates, multiplier bits drain from the low end.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : (WIDTH+1)'(0));

  // Restoring step: bit WIDTH of the trial difference is the borrow.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opd};
  assign div_ge    = ~div_diff[WIDTH];

  // State and registered status outputs
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      div_zero <= div_zero_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (!op_is_div)   state_nx = ST_MUL;
          else if (rt_zero) state_nx = ST_DONE;
          else              state_nx = ST_DIV;
        end
      end
      ST_MUL:  if (last_iter) state_nx = ST_FIX;
      ST_DIV:  if (last_iter) state_nx = ST_FIX;
      ST_FIX:  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output next values, registered alongside the state
  always_comb begin
    busy_nx     = 1'b0;
    done_nx     = 1'b0;
    div_zero_nx = 1'b0;
    case (state_nx)
      ST_MUL, ST_DIV, ST_FIX: busy_nx = 1'b1;
      ST_DONE:                done_nx = 1'b1;
      default:                ;
    endcase
    if (accept && op_is_div && rt_zero) div_zero_nx = 1'b1;
  end

  // Iteration datapath and HI/LO registers
  always_ff @(posedge Clk) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      opd    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      div_op <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt    <= '0;
            sign_q <= op_sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            sign_r <= op_sgn & rs_val[WIDTH-1];
            div_op <= op_is_div;
            if (op_is_div) begin
              opd <= b_mag;
              acc <= {WIDTH'(0), a_mag};
              if (rt_zero) begin
                hi <= rs_val;
                lo <= '1;
              end
            end else begin
              opd <= a_mag;
              acc <= {WIDTH'(0), b_mag};
            end
          end else if (hilo_we) begin
            if (hilo_sel) hi <= hilo_wdata;
            else          lo <= hilo_wdata;
          end
        end
        ST_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        ST_DIV: begin
          acc <= {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
          cnt <= cnt + CNT_W'(1);
        end
        ST_FIX: begin
          if (div_op) begin
            lo <= sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi <= sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end else begin
            {hi, lo} <= sign_q ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
